// File: rtl/uart_rx_pkg.sv
// Shared definitions for the MIDI UART: frame geometry and receiver state encoding.
package uart_rx_pkg;

    localparam int unsigned OVERSAMPLE = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W      = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the pin through the chain every clock; reset to the line's idle level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first serial receiver driven by an 8x oversample tick.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SAMPLE_PT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              rx_strobe,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SAMPLE_CNT = SAMPLE_PT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAST_CNT   = '1;
    localparam logic [BIT_W-1:0] LAST_BIT   = '1;

    logic              rx_s;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              strobe_q, strobe_d;
    logic              ferr_q, ferr_d;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // The sample/end decisions look at the value cnt takes on this tick, so
    // cnt tracks (ticks since the start-detect tick) mod 8.
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, counter and datapath decisions; everything holds without a tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        strobe_d  = 1'b0;
        ferr_d    = 1'b0;
        if (clk_en) begin
            cnt_d = cnt_inc;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_START;
                        bit_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (cnt_inc == SAMPLE_CNT && rx_s) begin
                        state_d = ST_IDLE;
                    end else if (cnt_inc == LAST_CNT) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_inc == SAMPLE_CNT) begin
                        sr_d = {rx_s, sr_q[DATA_W-1:1]};
                    end
                    if (cnt_inc == LAST_CNT) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt_inc == SAMPLE_CNT) begin
                        if (rx_s) begin
                            data_d   = sr_q;
                            strobe_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            strobe_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data      = data_q;
    assign rx_strobe = strobe_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a tick-based line driver plays the transmitter,
// and a frame-level model predicts which bytes and frame errors must appear.
module tb_uart_rx;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] data;
    logic       rx_strobe;
    logic       frame_err;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned gap_min = 4;
    int unsigned gap_max = 4;
    logic        abort   = 1'b0;

    int unsigned tick_no  = 0;
    int unsigned ferr_cnt = 0;
    logic [7:0]  got_q[$];
    int unsigned strobe_tick_q[$];

    logic [7:0]  exp_q[$];
    logic [7:0]  last_good = 8'h00;

    uart_rx #(
        .SYNC_STAGES (2),
        .SAMPLE_PT   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .rx        (rx),
        .data      (data),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk wide, spacing drawn from [gap_min, gap_max] clocks.
    initial begin
        forever begin
            int unsigned g;
            g = $urandom_range(gap_max, gap_min);
            repeat (g - 1) @(negedge clk);
            clk_en = 1'b1;
            @(negedge clk);
            clk_en = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: records strobed bytes with their tick index and counts frame errors.
    initial begin
        forever begin
            @(posedge clk);
            if (clk_en) tick_no++;
            #1;
            if (rx_strobe) begin
                got_q.push_back(data);
                strobe_tick_q.push_back(tick_no);
                check_eq("busy_after_stop", {31'd0, busy}, 32'd0);
            end
            if (frame_err) ferr_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at tick %0d", tick_no);
        $fatal(1, "timeout");
    end

    task automatic wait_tick();
        do @(posedge clk); while (clk_en !== 1'b1);
        #1;
    endtask

    // Drive one frame starting right after a tick; bit boundaries follow a
    // skewed baud rate (skew in parts per thousand), rounded to whole ticks.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int skew_pm);
        int bnd0, bnd1;
        for (int k = 0; k < 10; k++) begin
            if (abort) return;
            if (k == 0)      rx = 1'b0;
            else if (k <= 8) rx = b[k-1];
            else             rx = stop_bit;
            bnd0 = (k * 8 * (1000 + skew_pm) + 500) / 1000;
            bnd1 = ((k + 1) * 8 * (1000 + skew_pm) + 500) / 1000;
            for (int t = 0; t < bnd1 - bnd0; t++) begin
                wait_tick();
                if (abort) return;
            end
        end
    endtask

    task automatic send_good(input logic [7:0] b, input int skew_pm);
        send_frame(b, 1'b1, skew_pm);
        exp_q.push_back(b);
        last_good = b;
    endtask

    task automatic settle_compare(input string tag, input int exp_ferr);
        repeat (24) wait_tick();
        check_eq({tag, "_nstrobe"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check_eq($sformatf("%s_data%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        check_eq({tag, "_nferr"}, ferr_cnt, exp_ferr);
        check_eq({tag, "_held"}, {24'd0, data}, {24'd0, last_good});
        got_q.delete();
        exp_q.delete();
        strobe_tick_q.delete();
        ferr_cnt = 0;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_data",   {24'd0, data}, 32'd0);
        check_eq("rst_strobe", {31'd0, rx_strobe}, 32'd0);
        check_eq("rst_ferr",   {31'd0, frame_err}, 32'd0);
        check_eq("rst_busy",   {31'd0, busy}, 32'd0);
        rst = 1'b1;
        repeat (10) wait_tick();

        // Single frame
        wait_tick();
        send_good(8'h90, 0);
        settle_compare("single", 0);

        // Two-tick glitch is rejected at the start-bit check
        wait_tick();
        rx = 1'b0;
        wait_tick();
        check_eq("glitch_busy_t0", {31'd0, busy}, 32'd1);
        wait_tick();
        rx = 1'b1;
        wait_tick();
        check_eq("glitch_busy_t2", {31'd0, busy}, 32'd1);
        wait_tick();
        check_eq("glitch_idle_t3", {31'd0, busy}, 32'd0);
        settle_compare("glitch", 0);

        // Bad stop bit followed by a held break, then a good frame
        wait_tick();
        send_frame(8'h55, 1'b0, 0);
        repeat (40) wait_tick();
        rx = 1'b1;
        check_eq("break_busy", {31'd0, busy}, 32'd1);
        wait_tick();
        check_eq("break_idle", {31'd0, busy}, 32'd0);
        repeat (4) wait_tick();
        send_good(8'h3C, 0);
        settle_compare("break", 1);

        // Back-to-back frames, no idle gap
        wait_tick();
        send_good(8'h90, 0);
        send_good(8'h3C, 0);
        send_good(8'h7F, 0);
        repeat (10) wait_tick();
        check_eq("b2b_count", strobe_tick_q.size(), 3);
        if (strobe_tick_q.size() >= 3) begin
            check_eq("b2b_gap01", strobe_tick_q[1] - strobe_tick_q[0], 80);
            check_eq("b2b_gap12", strobe_tick_q[2] - strobe_tick_q[1], 80);
        end
        settle_compare("b2b", 0);

        // Reset 40 ticks into a frame aborts it
        wait_tick();
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                repeat (41) wait_tick();
                rst   = 1'b0;
                abort = 1'b1;
            end
        join
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_data",   {24'd0, data}, 32'd0);
        check_eq("midrst_strobe", {31'd0, rx_strobe}, 32'd0);
        check_eq("midrst_ferr",   {31'd0, frame_err}, 32'd0);
        check_eq("midrst_busy",   {31'd0, busy}, 32'd0);
        rst       = 1'b1;
        abort     = 1'b0;
        last_good = 8'h00;
        repeat (20) wait_tick();
        send_good(8'hF8, 0);
        settle_compare("midrst", 0);

        // Irregular tick spacing with +/-3% baud skew
        gap_min = 3;
        gap_max = 6;
        repeat (4) wait_tick();
        send_good(8'h00, 30);
        send_good(8'hFF, -30);
        send_good(8'h00, -30);
        send_good(8'hFF, 30);
        settle_compare("skew_edge", 0);

        // Random bytes, random skew, random idle gaps
        for (int n = 0; n < 8; n++) begin
            logic [7:0] b;
            int         sk;
            int unsigned gap;
            b   = 8'($urandom);
            sk  = int'($urandom_range(60)) - 30;
            gap = $urandom_range(5);
            repeat (gap) wait_tick();
            send_good(b, sk);
        end
        settle_compare("random", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
